vector_control_unit: RTL and testbench
======================================

Name: vector_control_unit

Overview:
Multi-cycle successor to the single-cycle combinational control unit of the vector ASIP. It accepts one instruction per valid/ready handshake, decodes the 4-bit opcode and sequences vector operations over ceil(VLEN/LANES) lane groups. Each group waits on the Exe_Finished or Mem_Finished handshake before advancing, and the block drives a lane mask for partial last groups. It sits between fetch/decode and the execute/memory stages, and back-pressures fetch through Instr_Ready and Stall.

Parameters:
LANES, 4, elements processed per issue (lanes); 1 <= LANES <= VLEN.
VLEN, 16, elements per vector register; need not be a multiple of LANES.
GW, max(1,$clog2(ceil(VLEN/LANES))), derived localparam, Lane_Group width.

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
Instr_Valid  in  1  OpCode valid
OpCode  in  4  instruction opcode
Instr_Ready  out  1  block accepts an instruction this cycle
Mem_Finished  in  1  memory unit completed current group
Exe_Finished  in  1  execute unit completed current group
Issue  out  1  one-cycle pulse per group issued
Lane_Group  out  GW  index of current group
Lane_Mask  out  LANES  active lanes of current group
RegFileWE, MemWE  out  1 each  commit write enables
ExtendSelect, ALUSource, OpSource, WBSelect  out  1 each  datapath selects
BranchSelect, OpType, ALUControl  out  2 each  datapath controls
Stall  out  1  equals ~Instr_Ready
Finished  out  1  one-cycle completion pulse
Illegal  out  1  one-cycle pulse with Finished for an undefined opcode
Halted  out  1  sticky until rst

Behaviour:
- Reset behaviour:
  - State goes to IDLE and the group counter clears.
  - All outputs are 0, except Instr_Ready=1 and Stall=0 from the first post-reset cycle.
  - Reset mid-operation aborts with no commit.
- Decode table (OpType: 00 scalar, 01 vector ALU, 10 vector memory, 11 control):
  - 0000 NOP: scalar, no writes.
  - 0001 SADD: ALUControl=00, RegFileWE.
  - 0010 SSUB: ALUControl=01, RegFileWE.
  - 0011 SADDI: ALUSource=1, ExtendSelect=1, RegFileWE.
  - 0100 VADD: 00. 0101 VSUB: 01. 0110 VMUL: 10. 0111 VXOR: 11. All with OpSource=1 and RegFileWE.
  - 1000 VLD: WBSelect=1, RegFileWE.
  - 1001 VST: MemWE.
  - 1010 B: BranchSelect=01. 1011 BEQ: BranchSelect=10.
  - 1100 HALT.
  - 1101-1111 illegal.
- FSM states: IDLE, ISSUE, WAIT_EXE, WAIT_MEM, DONE, HALT.
  - IDLE: Instr_Ready=1. When Instr_Valid=1, latch OpCode and go to ISSUE, with Lane_Group=0.
  - ISSUE: Issue=1. Decoded selects are driven from the latched opcode and held through the WAIT states; they are 0 in IDLE, DONE and HALT.
    - Scalar and control: commit in ISSUE, then go to DONE. Latency is accept-to-Finished = 2 cycles.
    - Vector ALU: go to WAIT_EXE.
    - Vector memory: go to WAIT_MEM.
    - Illegal: go to DONE with Illegal latched; no write enables.
    - HALT: go to HALT.
  - WAIT_EXE / WAIT_MEM: wait for the matching Finished input only; the other one is ignored.
    - Finished inputs are never sampled in ISSUE, so each group takes at least 2 cycles.
    - The commit cycle is the cycle the matching Finished input is 1. RegFileWE/MemWE pulse exactly then.
    - After commit: if this is the last group, go to DONE; otherwise increment Lane_Group and go to ISSUE.
  - DONE: Finished=1 (plus Illegal if latched) for one cycle, then go to IDLE.
  - HALT: Halted=1, Instr_Ready=0. Absorbing until rst.
- Lane_Mask:
  - All ones, except the last group, which has the low VLEN-(NG-1)*LANES bits set, where NG=ceil(VLEN/LANES).
  - Scalar ops: mask = 1 (lane 0 only).
- Stall: 1 in every state except IDLE.

Decomposition:
- vector_cu_pkg:
  - opcode enum, OpType enum and ALUControl enum
  - state enum
  - ctrl_t struct (all decoded control fields)
  - function num_groups(VLEN, LANES)
- Sub-module vector_decoder: purely combinational, OpCode -> ctrl_t plus an is_illegal flag. The FSM and group counter stay in vector_control_unit.

Test Plan:
1. rst then SADD (0001) -> Issue for 1 cycle with RegFileWE=1, ALUControl=00, OpType=00; Finished 2 cycles after accept; Instr_Ready=1 the following cycle.
2. VADD with LANES=4, VLEN=16, Exe_Finished pulsed 2 cycles after each Issue -> 4 Issue pulses with Lane_Group 0,1,2,3; exactly 4 RegFileWE pulses; Lane_Mask=1111 throughout; a single Finished.
3. VLD with LANES=4, VLEN=10, Mem_Finished tied to 1 -> 3 groups with Lane_Mask 1111, 1111, 0011; each group takes exactly 2 cycles; WBSelect=1.
4. VST with Exe_Finished=1 and Mem_Finished=0 for 20 cycles -> remains in WAIT_MEM with MemWE=0 and Stall=1; Mem_Finished=1 -> one MemWE pulse.
5. OpCode 1110 -> Illegal and Finished pulse together; RegFileWE=MemWE=0 throughout. Then HALT (1100) -> Halted=1, and a later Instr_Valid is ignored (no Issue).
6. rst asserted during group 2 of VADD -> next cycle IDLE, Lane_Group=0, all enables 0, no Finished pulse.

Source files
------------

// File: rtl/vector_cu_pkg.sv
// vector_cu_pkg: shared opcode/state types, decoded control bundle and group-count helper
package vector_cu_pkg;
    typedef enum logic [3:0] {
        OP_NOP, OP_SADD, OP_SSUB, OP_SADDI,
        OP_VADD, OP_VSUB, OP_VMUL, OP_VXOR,
        OP_VLD, OP_VST, OP_B, OP_BEQ, OP_HALT
    } opcode_e;
    typedef enum logic [1:0] {OT_SCALAR, OT_VALU, OT_VMEM, OT_CTRL} optype_e;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_MUL, ALU_XOR} aluctl_e;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_EXE, S_WAIT_MEM, S_DONE, S_HALT} state_e;
    typedef struct packed {
        logic       reg_we;
        logic       mem_we;
        logic       extend_sel;
        logic       alu_src;
        logic       op_src;
        logic       wb_sel;
        logic [1:0] branch_sel;
        optype_e    op_type;
        aluctl_e    alu_ctl;
    } ctrl_t;
    function automatic int num_groups(input int vlen, input int lanes);
        return (vlen + lanes - 1) / lanes;
    endfunction
endpackage

// File: rtl/vector_decoder.sv
// vector_decoder: combinational opcode to control-bundle decode with illegal-opcode flag
module vector_decoder
    import vector_cu_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl,
    output logic       is_illegal
);
    always_comb begin
        ctrl = '0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_SADD: ctrl.reg_we = 1'b1;
            OP_SSUB: begin
                ctrl.reg_we = 1'b1;
                ctrl.alu_ctl = ALU_SUB;
            end
            OP_SADDI: begin
                ctrl.reg_we = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.extend_sel = 1'b1;
            end
            OP_VADD, OP_VSUB, OP_VMUL, OP_VXOR: begin
                ctrl.reg_we = 1'b1;
                ctrl.op_src = 1'b1;
                ctrl.op_type = OT_VALU;
                ctrl.alu_ctl = aluctl_e'(opcode[1:0]);
            end
            OP_VLD: begin
                ctrl.reg_we = 1'b1;
                ctrl.wb_sel = 1'b1;
                ctrl.op_type = OT_VMEM;
            end
            OP_VST: begin
                ctrl.mem_we = 1'b1;
                ctrl.op_type = OT_VMEM;
            end
            OP_B: begin
                ctrl.branch_sel = 2'b01;
                ctrl.op_type = OT_CTRL;
            end
            OP_BEQ: begin
                ctrl.branch_sel = 2'b10;
                ctrl.op_type = OT_CTRL;
            end
            OP_HALT: ctrl.op_type = OT_CTRL;
            default: is_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/vector_control_unit.sv
// vector_control_unit: multi-cycle issue sequencer stepping vector ops over lane groups
module vector_control_unit
    import vector_cu_pkg::*;
#(
    parameter int LANES = 4,
    parameter int VLEN = 16,
    localparam int NG = num_groups(VLEN, LANES),
    localparam int GW = NG > 1 ? $clog2(NG) : 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             Instr_Valid,
    input  logic [3:0]       OpCode,
    output logic             Instr_Ready,
    input  logic             Mem_Finished,
    input  logic             Exe_Finished,
    output logic             Issue,
    output logic [GW-1:0]    Lane_Group,
    output logic [LANES-1:0] Lane_Mask,
    output logic             RegFileWE,
    output logic             MemWE,
    output logic             ExtendSelect,
    output logic             ALUSource,
    output logic             OpSource,
    output logic             WBSelect,
    output logic [1:0]       BranchSelect,
    output logic [1:0]       OpType,
    output logic [1:0]       ALUControl,
    output logic             Stall,
    output logic             Finished,
    output logic             Illegal,
    output logic             Halted
);
    localparam logic [LANES-1:0] LAST_MASK = {LANES{1'b1}} >> (LANES - (VLEN - (NG - 1) * LANES));
    state_e state, state_n;
    logic [3:0] op_q;
    logic [GW-1:0] grp;
    ctrl_t ctrl;
    logic illegal_op, active, vec, last, commit;
    vector_decoder u_dec (.opcode(op_q), .ctrl(ctrl), .is_illegal(illegal_op));
    assign active = state inside {S_ISSUE, S_WAIT_EXE, S_WAIT_MEM};
    assign vec = ctrl.op_type inside {OT_VALU, OT_VMEM};
    assign last = grp == GW'(NG - 1);
    assign commit = state == S_ISSUE ? !vec :
                    state == S_WAIT_EXE ? Exe_Finished :
                    state == S_WAIT_MEM && Mem_Finished;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_q <= '0;
            grp <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE) begin
                grp <= '0;
                if (Instr_Valid) op_q <= OpCode;
            end else if (commit && state != S_ISSUE && !last) begin
                grp <= grp + GW'(1);
            end
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: state_n = Instr_Valid ? S_ISSUE : S_IDLE;
            S_ISSUE: state_n = op_q == OP_HALT ? S_HALT :
                               !vec ? S_DONE :
                               ctrl.op_type == OT_VALU ? S_WAIT_EXE : S_WAIT_MEM;
            S_WAIT_EXE, S_WAIT_MEM: state_n = !commit ? state : last ? S_DONE : S_ISSUE;
            S_DONE: state_n = S_IDLE;
            default: state_n = state;
        endcase
    end
    assign Instr_Ready = state == S_IDLE;
    assign Stall = !Instr_Ready;
    assign Issue = state == S_ISSUE;
    assign Lane_Group = active ? grp : '0;
    assign Lane_Mask = !active ? '0 : !vec ? LANES'(1) : last ? LAST_MASK : '1;
    assign RegFileWE = commit && ctrl.reg_we;
    assign MemWE = commit && ctrl.mem_we;
    assign ExtendSelect = active && ctrl.extend_sel;
    assign ALUSource = active && ctrl.alu_src;
    assign OpSource = active && ctrl.op_src;
    assign WBSelect = active && ctrl.wb_sel;
    assign BranchSelect = active ? ctrl.branch_sel : 2'b00;
    assign OpType = active ? ctrl.op_type : 2'b00;
    assign ALUControl = active ? ctrl.alu_ctl : 2'b00;
    assign Finished = state == S_DONE;
    assign Illegal = Finished && illegal_op;
    assign Halted = state == S_HALT;
endmodule

// File: tb/tb_vector_control_unit.sv
// tb_vector_control_unit: randomized scenario bench against a table-driven instruction model
module tb_vector_control_unit;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic iv, ef, mf;
    logic [3:0] opc;
    logic ready, stall, issue, fin, ill, halt, rwe, mwe, ext, alus, ops, wbs;
    logic [1:0] br, ot, alu, grp;
    logic [3:0] mask;
    logic iv10, mf10;
    logic [3:0] op10;
    logic r10, s10, is10, f10, il10, h10, rwe10, mwe10, e10, a10, o10, wb10;
    logic [1:0] br10, ot10, al10, g10;
    logic [3:0] m10;
    logic [13:0] obs;
    logic [9:0] sel;
    int ncmp = 0, nerr = 0;
    assign obs = {ready, stall, issue, fin, ill, halt, rwe, mwe, grp, mask};
    assign sel = {ext, alus, ops, wbs, br, ot, alu};

    vector_control_unit #(.LANES(4), .VLEN(16)) dut (
        .clk(clk), .rst(rst), .Instr_Valid(iv), .OpCode(opc), .Instr_Ready(ready),
        .Mem_Finished(mf), .Exe_Finished(ef), .Issue(issue), .Lane_Group(grp), .Lane_Mask(mask),
        .RegFileWE(rwe), .MemWE(mwe), .ExtendSelect(ext), .ALUSource(alus), .OpSource(ops),
        .WBSelect(wbs), .BranchSelect(br), .OpType(ot), .ALUControl(alu), .Stall(stall),
        .Finished(fin), .Illegal(ill), .Halted(halt)
    );
    vector_control_unit #(.LANES(4), .VLEN(10)) dut10 (
        .clk(clk), .rst(rst), .Instr_Valid(iv10), .OpCode(op10), .Instr_Ready(r10),
        .Mem_Finished(mf10), .Exe_Finished(1'b0), .Issue(is10), .Lane_Group(g10), .Lane_Mask(m10),
        .RegFileWE(rwe10), .MemWE(mwe10), .ExtendSelect(e10), .ALUSource(a10), .OpSource(o10),
        .WBSelect(wb10), .BranchSelect(br10), .OpType(ot10), .ALUControl(al10), .Stall(s10),
        .Finished(f10), .Illegal(il10), .Halted(h10)
    );

    // {RegFileWE, MemWE, ExtendSelect, ALUSource, OpSource, WBSelect, BranchSelect, OpType, ALUControl}
    function automatic logic [11:0] ref_dec(input logic [3:0] op);
        case (op)
            4'd1: return 12'b10_0000_00_00_00;
            4'd2: return 12'b10_0000_00_00_01;
            4'd3: return 12'b10_1100_00_00_00;
            4'd4, 4'd5, 4'd6, 4'd7: return {6'b10_0010, 4'b00_01, op[1:0]};
            4'd8: return 12'b10_0001_00_10_00;
            4'd9: return 12'b01_0000_00_10_00;
            4'd10: return 12'b00_0000_01_11_00;
            4'd11: return 12'b00_0000_10_11_00;
            4'd12: return 12'b00_0000_00_11_00;
            default: return 12'b0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input int dlo, input int dhi);
        logic [11:0] d = ref_dec(op);
        bit vec = op inside {[4:9]};
        bit memop = op inside {8, 9};
        int ng = vec ? (16 + 3) / 4 : 1;
        int n;
        logic [3:0] m;
        iv = 1'b1; opc = op; ef = 1'b0; mf = 1'b0; #1;
        ncmp++;
        if (ready !== 1'b1) begin nerr++; $display("FAIL accept op=%0d: Instr_Ready=%b want 1", op, ready); end
        tick();
        iv = 1'b0; opc = 4'($urandom);
        for (int g = 0; g < ng; g++) begin
            n = 16 - g * 4 < 4 ? 16 - g * 4 : 4;
            m = vec ? 4'((1 << n) - 1) : 4'h1;
            ef = 1'($urandom); mf = 1'($urandom); #1;
            ncmp++;
            if ({obs, sel} !== {6'b011000, !vec && d[11], 1'b0, 2'(g), m, d[9:0]}) begin
                nerr++; $display("FAIL issue op=%0d g=%0d: got %h/%h want %h/%h", op, g, obs, sel,
                                 {6'b011000, !vec && d[11], 1'b0, 2'(g), m}, d[9:0]);
            end
            tick();
            if (vec) begin
                int w = $urandom_range(dhi, dlo);
                for (int k = 0; k <= w; k++) begin
                    if (memop) begin mf = k == w; ef = 1'($urandom); end
                    else begin ef = k == w; mf = 1'($urandom); end
                    #1;
                    ncmp++;
                    if ({obs, sel} !== {6'b010000, k == w && d[11], k == w && d[10], 2'(g), m, d[9:0]}) begin
                        nerr++; $display("FAIL wait op=%0d g=%0d k=%0d: got %h/%h want %h/%h", op, g, k, obs, sel,
                                         {6'b010000, k == w && d[11], k == w && d[10], 2'(g), m}, d[9:0]);
                    end
                    tick();
                end
            end
        end
        ef = 1'b0; mf = 1'b0; #1;
        ncmp++;
        if ({obs, sel} !== {6'b010100, 18'b0}) begin
            nerr++; $display("FAIL done op=%0d: got %h/%h want %h/000", op, obs, sel, {6'b010100, 8'b0});
        end
        tick();
        ncmp++;
        if ({obs, sel} !== {6'b100000, 18'b0}) begin
            nerr++; $display("FAIL idle op=%0d: got %h/%h want %h/000", op, obs, sel, {6'b100000, 8'b0});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
        ncmp++;
        if ({obs, sel} !== {6'b100000, 18'b0}) begin
            nerr++; $display("FAIL reset: got %h/%h want %h/000", obs, sel, {6'b100000, 8'b0});
        end
    endtask

    task automatic test_scalar;
        logic [3:0] list [6] = '{4'd1, 4'd0, 4'd2, 4'd3, 4'd10, 4'd11};
        foreach (list[i]) run_op(list[i], 0, 0);
    endtask

    task automatic test_vadd;
        run_op(4'd4, 1, 1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) run_op(4'($urandom_range(11, 0)), 0, 3);
    endtask

    task automatic test_vld10;
        logic [3:0] m;
        iv10 = 1'b1; op10 = 4'd8; mf10 = 1'b1; #1;
        ncmp++;
        if (r10 !== 1'b1) begin nerr++; $display("FAIL vld10 accept: Instr_Ready=%b want 1", r10); end
        tick();
        iv10 = 1'b0;
        for (int g = 0; g < 3; g++) begin
            m = g == 2 ? 4'h3 : 4'hF;
            #1;
            ncmp++;
            if ({is10, g10, m10, rwe10, wb10, ot10} !== {1'b1, 2'(g), m, 1'b0, 1'b1, 2'b10}) begin
                nerr++; $display("FAIL vld10 issue g=%0d: got %b want %b", g, {is10, g10, m10, rwe10, wb10, ot10},
                                 {1'b1, 2'(g), m, 1'b0, 1'b1, 2'b10});
            end
            tick(); #1;
            ncmp++;
            if ({is10, g10, m10, rwe10, wb10} !== {1'b0, 2'(g), m, 1'b1, 1'b1}) begin
                nerr++; $display("FAIL vld10 wait g=%0d: got %b want %b", g, {is10, g10, m10, rwe10, wb10},
                                 {1'b0, 2'(g), m, 1'b1, 1'b1});
            end
            tick();
        end
        #1;
        ncmp++;
        if ({f10, is10, rwe10} !== 3'b100) begin nerr++; $display("FAIL vld10 done: got %b want 100", {f10, is10, rwe10}); end
        tick(); #1;
        ncmp++;
        if ({r10, f10} !== 2'b10) begin nerr++; $display("FAIL vld10 idle: got %b want 10", {r10, f10}); end
    endtask

    task automatic test_vst_stall;
        int pulses = 0;
        bit done = 0;
        iv = 1'b1; opc = 4'd9; ef = 1'b1; mf = 1'b0; #1;
        tick();
        iv = 1'b0; #1;
        ncmp++;
        if ({issue, grp, mwe} !== 4'b1000) begin nerr++; $display("FAIL vst issue: got %b want 1000", {issue, grp, mwe}); end
        tick();
        for (int k = 0; k < 20; k++) begin
            #1;
            ncmp++;
            if ({issue, mwe, stall, grp} !== 5'b00100) begin
                nerr++; $display("FAIL vst stall k=%0d: got %b want 00100", k, {issue, mwe, stall, grp});
            end
            tick();
        end
        mf = 1'b1; #1;
        ncmp++;
        if ({issue, mwe, grp} !== 4'b0100) begin nerr++; $display("FAIL vst commit: got %b want 0100", {issue, mwe, grp}); end
        tick(); #1;
        ncmp++;
        if ({issue, mwe, grp} !== 4'b1001) begin nerr++; $display("FAIL vst next group: got %b want 1001", {issue, mwe, grp}); end
        for (int c = 0; c < 20 && !done; c++) begin
            tick(); #1;
            if (fin) done = 1;
            else pulses += int'(mwe);
        end
        ncmp++;
        if (!done || pulses != 3) begin nerr++; $display("FAIL vst tail: done=%0d pulses=%0d want 1/3", done, pulses); end
        mf = 1'b0; ef = 1'b0;
        tick();
    endtask

    task automatic test_illegal_halt;
        iv = 1'b1; opc = 4'd14; ef = 1'b1; mf = 1'b1; #1;
        tick();
        iv = 1'b0; #1;
        ncmp++;
        if ({issue, rwe, mwe, fin, ill, ot} !== 7'b1000000) begin
            nerr++; $display("FAIL illegal issue: got %b want 1000000", {issue, rwe, mwe, fin, ill, ot});
        end
        tick(); #1;
        ncmp++;
        if ({fin, ill, rwe, mwe, issue} !== 5'b11000) begin
            nerr++; $display("FAIL illegal done: got %b want 11000", {fin, ill, rwe, mwe, issue});
        end
        tick(); #1;
        ncmp++;
        if ({ready, ill, fin} !== 3'b100) begin nerr++; $display("FAIL illegal idle: got %b want 100", {ready, ill, fin}); end
        iv = 1'b1; opc = 4'd12; #1;
        tick();
        iv = 1'b0; #1;
        ncmp++;
        if ({issue, ot, halt} !== 4'b1110) begin nerr++; $display("FAIL halt issue: got %b want 1110", {issue, ot, halt}); end
        tick(); #1;
        ncmp++;
        if ({halt, ready, stall, issue} !== 4'b1010) begin
            nerr++; $display("FAIL halted: got %b want 1010", {halt, ready, stall, issue});
        end
        iv = 1'b1; opc = 4'd1;
        for (int k = 0; k < 6; k++) begin
            tick();
            ncmp++;
            if ({halt, ready, issue, rwe, fin} !== 5'b10000) begin
                nerr++; $display("FAIL halt absorb k=%0d: got %b want 10000", k, {halt, ready, issue, rwe, fin});
            end
        end
        iv = 1'b0; ef = 1'b0; mf = 1'b0;
    endtask

    task automatic test_reset_mid;
        rst = 1'b1; tick(); rst = 1'b0;
        iv = 1'b1; opc = 4'd4; ef = 1'b0; mf = 1'b0; #1;
        tick();
        iv = 1'b0;
        for (int g = 0; g < 2; g++) begin
            tick(); ef = 1'b1;
            tick(); ef = 1'b0;
        end
        tick();
        ef = 1'b1; rst = 1'b1; #1;
        ncmp++;
        if ({issue, grp} !== 3'b010) begin nerr++; $display("FAIL pre-abort group: got %b want 010", {issue, grp}); end
        tick();
        rst = 1'b0; ef = 1'b0; #1;
        ncmp++;
        if ({obs, sel} !== {6'b100000, 18'b0}) begin
            nerr++; $display("FAIL abort: got %h/%h want %h/000", obs, sel, {6'b100000, 8'b0});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            ncmp++;
            if ({fin, issue, rwe} !== 3'b000) begin nerr++; $display("FAIL abort quiet k=%0d: got %b want 000", k, {fin, issue, rwe}); end
        end
    endtask

    initial begin
        iv = 1'b0; ef = 1'b0; mf = 1'b0; opc = 4'd0;
        iv10 = 1'b0; op10 = 4'd0; mf10 = 1'b0;
        test_reset();
        test_scalar();
        test_vadd();
        test_vld10();
        test_vst_stall();
        test_random();
        test_illegal_halt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
